// File: rtl/ifetch_if.sv
// ifetch_if: instruction-memory read bus between the fetch stage (master) and memory (slave)
interface ifetch_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (output imem_addr, imem_req, input imem_rdata, imem_ready);
    modport slave  (input imem_addr, imem_req, output imem_rdata, imem_ready);
endinterface

// File: rtl/ifetch.sv
// ifetch: PC owner and instruction fetch stage; `define IFETCH_SQUASH_EN squashes the delay slot on redirect
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    input  logic              jmp,
    input  logic [25:0]       jmp_ad,
    ifetch_if.master          imem,
    output logic [31:0]       pcp4,
    output logic [31:0]       ins,
    output logic              ins_valid
);
    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_ins_q, hold_ins_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic        qual;
    logic        adv;
    logic [31:0] tgt;
    logic [31:0] next_pc;
    logic        unused_ok;

    assign unused_ok = ^br_target[1:0];

    // Redirect qualification, target choice and next-PC priority
    always_comb begin
        qual    = !stall && (jmp || br_taken);
        tgt     = jmp ? {pc_q[31:28], jmp_ad, 2'b00} : {br_target[31:2], 2'b00};
        adv     = !stall && (state_q == HOLD || imem.imem_ready);
        next_pc = qual ? tgt : redir_pend_q ? redir_pc_q : pc_q + 32'd4;
    end

    // Next-state: advance consumes the redirect, otherwise it is parked; a stalled return is held
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_ins_d   = hold_ins_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        if (adv) begin
            pc_d         = next_pc;
            redir_pend_d = 1'b0;
            state_d      = FETCH;
        end else if (qual) begin
            redir_pc_d   = tgt;
            redir_pend_d = 1'b1;
        end
        if (state_q == FETCH && imem.imem_ready && stall) begin
            hold_ins_d = imem.imem_rdata;
            state_d    = HOLD;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            hold_ins_q   <= 32'd0;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_ins_q   <= hold_ins_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
        end
    end

    // Outputs: memory data passes straight through in FETCH, held word in HOLD, silent in reset
    always_comb begin
        imem.imem_addr = pc_q;
        imem.imem_req  = !rst && state_q == FETCH;
        pcp4           = rst ? RESET_PC + 32'd4 : pc_q + 32'd4;
        ins            = rst ? 32'd0 : state_q == HOLD ? hold_ins_q :
                         imem.imem_ready ? imem.imem_rdata : 32'd0;
        ins_valid      = !rst && (state_q == HOLD || imem.imem_ready);
`ifdef IFETCH_SQUASH_EN
        if (adv && (qual || redir_pend_q)) begin
            ins       = 32'd0;
            ins_valid = 1'b0;
        end
`endif
    end
endmodule
